// File: rtl/cpu7_exc_ctl_pkg.sv
//============================================================================
// Module      : cpu7_exc_ctl_pkg
// Description : Exception codes and FSM encodings shared by the exception
//               control stage.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

package cpu7_exc_ctl_pkg;

    localparam logic [5:0] ECODE_INT = 6'h00;
    localparam logic [5:0] ECODE_ALE = 6'h09;
    localparam logic [5:0] ECODE_SYS = 6'h0B;
    localparam logic [5:0] ECODE_BRK = 6'h0C;
    localparam logic [5:0] ECODE_INE = 6'h0D;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REDIR = 2'd1,
        ST_DRAIN = 2'd2
    } exc_state_e;

endpackage

`default_nettype wire

// File: rtl/cpu7_exc_ctl_if.sv
//============================================================================
// Module      : cpu7_exc_ctl_if
// Description : Pipeline/CSR/IFU signals seen by the exception control stage.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

interface cpu7_exc_ctl_if #(
    parameter int GRLEN = 32
);
    logic             csr_ecl_timer_intr;
    logic             csr_ecl_crmd_ie;
    logic [GRLEN-1:0] csr_eentry;
    logic [GRLEN-1:0] csr_era;
    logic             valid_e;
    logic [GRLEN-1:0] pc_e;
    logic             ine_e;
    logic             sys_e;
    logic             brk_e;
    logic             ale_e;
    logic             ertn_e;
    logic [GRLEN-1:0] lsu_addr_e;
    logic             ifu_exu_redirect_ack;
    logic             exu_ifu_except;
    logic [5:0]       ecl_csr_exccode_e;
    logic [GRLEN-1:0] ecl_csr_badv_e;
    logic             ecl_csr_ertn_e;
    logic             exu_ifu_redirect;
    logic [GRLEN-1:0] exu_ifu_redirect_pc;
    logic             ecl_kill_e;

    // master: pipeline/CSR/IFU environment; slave: the exception controller
    modport master (
        output csr_ecl_timer_intr, csr_ecl_crmd_ie, csr_eentry, csr_era,
               valid_e, pc_e, ine_e, sys_e, brk_e, ale_e, ertn_e,
               lsu_addr_e, ifu_exu_redirect_ack,
        input  exu_ifu_except, ecl_csr_exccode_e, ecl_csr_badv_e,
               ecl_csr_ertn_e, exu_ifu_redirect, exu_ifu_redirect_pc,
               ecl_kill_e
    );

    modport slave (
        input  csr_ecl_timer_intr, csr_ecl_crmd_ie, csr_eentry, csr_era,
               valid_e, pc_e, ine_e, sys_e, brk_e, ale_e, ertn_e,
               lsu_addr_e, ifu_exu_redirect_ack,
        output exu_ifu_except, ecl_csr_exccode_e, ecl_csr_badv_e,
               ecl_csr_ertn_e, exu_ifu_redirect, exu_ifu_redirect_pc,
               ecl_kill_e
    );

endinterface

`default_nettype wire

// File: rtl/cpu7_sync_ff.sv
//============================================================================
// Module      : cpu7_sync_ff
// Description : Parameterised-depth flop synchronizer for async level inputs.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module cpu7_sync_ff #(
    parameter int STAGES = 2
) (
    input  wire logic clk,
    input  wire logic resetn,
    input  wire logic d,
    output logic      q
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

`default_nettype wire

// File: rtl/cpu7_exc_ctl.sv
//============================================================================
// Module      : cpu7_exc_ctl
// Description : Arbitrates exceptions, interrupts and ERTN into CSR event
//               pulses and owns the IFU redirect / pipeline-kill window.
//               Define CPU7_EXC_CNT_EN to add exc_cnt/int_cnt event counters.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module cpu7_exc_ctl
    import cpu7_exc_ctl_pkg::*;
#(
    parameter int GRLEN       = 32,
    parameter int SYNC_STAGES = 2,
    parameter int DRAIN_CYC   = 2
) (
    input  wire logic     clk,
    input  wire logic     resetn,
    input  wire logic     ext_intr,
    cpu7_exc_ctl_if.slave bus
`ifdef CPU7_EXC_CNT_EN
    ,
    output logic [31:0]   exc_cnt,
    output logic [31:0]   int_cnt
`endif
);

    localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYC - 1);

    logic             ext_sync;
    logic             int_pend;
    logic             exc_req;
    logic             event_fire;
    logic             take_exc;
    logic             take_ertn;
    logic [5:0]       exc_code;
    logic [GRLEN-1:0] event_target;

    exc_state_e       state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [GRLEN-1:0] target_q, target_d;
    logic             redirect_q, redirect_d;
    logic             kill_q, kill_d;

    cpu7_sync_ff #(
        .STAGES (SYNC_STAGES)
    ) u_ext_sync (
        .clk    (clk),
        .resetn (resetn),
        .d      (ext_intr),
        .q      (ext_sync)
    );

    assign int_pend = bus.csr_ecl_crmd_ie & (bus.csr_ecl_timer_intr | ext_sync);
    assign exc_req  = int_pend | bus.ine_e | bus.sys_e | bus.brk_e | bus.ale_e;

    // Gating with resetn keeps the combinational event outputs low while reset is held
    assign event_fire = resetn & (state_q == ST_IDLE) & bus.valid_e
                      & (exc_req | bus.ertn_e);
    assign take_exc   = event_fire & exc_req;
    assign take_ertn  = event_fire & ~exc_req;

    always_comb begin
        exc_code = ECODE_INT;
        if (int_pend)       exc_code = ECODE_INT;
        else if (bus.ine_e) exc_code = ECODE_INE;
        else if (bus.sys_e) exc_code = ECODE_SYS;
        else if (bus.brk_e) exc_code = ECODE_BRK;
        else if (bus.ale_e) exc_code = ECODE_ALE;
    end

    assign event_target = take_exc ? bus.csr_eentry : bus.csr_era;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        target_d = target_q;
        case (state_q)
            ST_IDLE: begin
                if (event_fire) begin
                    target_d = event_target;
                    if (bus.ifu_exu_redirect_ack) begin
                        state_d = ST_DRAIN;
                        cnt_d   = DRAIN_LOAD;
                    end else begin
                        state_d = ST_REDIR;
                    end
                end
            end
            ST_REDIR: begin
                if (bus.ifu_exu_redirect_ack) begin
                    state_d = ST_DRAIN;
                    cnt_d   = DRAIN_LOAD;
                end
            end
            ST_DRAIN: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
        redirect_d = (state_d == ST_REDIR);
        kill_d     = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 4'd0;
            target_q   <= '0;
            redirect_q <= 1'b0;
            kill_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            target_q   <= target_d;
            redirect_q <= redirect_d;
            kill_q     <= kill_d;
        end
    end

    assign bus.exu_ifu_except      = take_exc;
    assign bus.ecl_csr_ertn_e      = take_ertn;
    assign bus.ecl_csr_exccode_e   = take_exc ? exc_code : 6'h00;
    assign bus.ecl_csr_badv_e      = !take_exc ? '0
                                   : (exc_code == ECODE_ALE) ? bus.lsu_addr_e : bus.pc_e;
    assign bus.exu_ifu_redirect    = event_fire | redirect_q;
    assign bus.exu_ifu_redirect_pc = event_fire ? event_target : target_q;
    assign bus.ecl_kill_e          = kill_q;

`ifdef CPU7_EXC_CNT_EN
    logic [31:0] exc_cnt_q, exc_cnt_d;
    logic [31:0] int_cnt_q, int_cnt_d;

    always_comb begin
        exc_cnt_d = exc_cnt_q;
        int_cnt_d = int_cnt_q;
        if (take_exc) begin
            exc_cnt_d = exc_cnt_q + 32'd1;
            if (exc_code == ECODE_INT) begin
                int_cnt_d = int_cnt_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            exc_cnt_q <= 32'd0;
            int_cnt_q <= 32'd0;
        end else begin
            exc_cnt_q <= exc_cnt_d;
            int_cnt_q <= int_cnt_d;
        end
    end

    assign exc_cnt = exc_cnt_q;
    assign int_cnt = int_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_cpu7_exc_ctl.sv
//============================================================================
// Module      : tb_cpu7_exc_ctl
// Description : Self-checking bench for cpu7_exc_ctl: directed scenarios plus
//               a randomized run against a behavioural event model.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_cpu7_exc_ctl;

    localparam int GRLEN = 32;
    localparam int SYNC  = 2;
    localparam int DRAIN = 2;
    localparam logic [31:0] EENTRY = 32'h1C00_0000;
    localparam logic [31:0] ERA    = 32'h0000_8000;

    logic clk      = 1'b0;
    logic resetn   = 1'b0;
    logic ext_intr = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    cpu7_exc_ctl_if #(.GRLEN(GRLEN)) bus ();

`ifdef CPU7_EXC_CNT_EN
    logic [31:0] exc_cnt;
    logic [31:0] int_cnt;
`endif

    cpu7_exc_ctl #(
        .GRLEN       (GRLEN),
        .SYNC_STAGES (SYNC),
        .DRAIN_CYC   (DRAIN)
    ) dut (
        .clk      (clk),
        .resetn   (resetn),
        .ext_intr (ext_intr),
        .bus      (bus)
`ifdef CPU7_EXC_CNT_EN
        ,
        .exc_cnt  (exc_cnt),
        .int_cnt  (int_cnt)
`endif
    );

    task automatic clear_reqs();
        bus.valid_e              = 1'b0;
        bus.ine_e                = 1'b0;
        bus.sys_e                = 1'b0;
        bus.brk_e                = 1'b0;
        bus.ale_e                = 1'b0;
        bus.ertn_e               = 1'b0;
        bus.ifu_exu_redirect_ack = 1'b0;
    endtask

    task automatic init_inputs();
        clear_reqs();
        bus.csr_ecl_timer_intr = 1'b0;
        bus.csr_ecl_crmd_ie    = 1'b0;
        bus.csr_eentry         = EENTRY;
        bus.csr_era            = ERA;
        bus.pc_e               = 32'h0;
        bus.lsu_addr_e         = 32'h0;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        init_inputs();
        bus.valid_e = 1'b1;
        bus.ine_e = 1'b1;
        bus.ifu_exu_redirect_ack = 1'b1;
        ext_intr = 1'b1;
        repeat (3) @(negedge clk);
        #2;
        n_checks++; if (bus.exu_ifu_except !== 1'b0) begin n_fail++; $display("FAIL rst_except: got %b want 0", bus.exu_ifu_except); end
        n_checks++; if (bus.ecl_csr_ertn_e !== 1'b0) begin n_fail++; $display("FAIL rst_ertn: got %b want 0", bus.ecl_csr_ertn_e); end
        n_checks++; if (bus.exu_ifu_redirect !== 1'b0) begin n_fail++; $display("FAIL rst_redirect: got %b want 0", bus.exu_ifu_redirect); end
        n_checks++; if (bus.ecl_kill_e !== 1'b0) begin n_fail++; $display("FAIL rst_kill: got %b want 0", bus.ecl_kill_e); end
        n_checks++; if (bus.ecl_csr_exccode_e !== 6'h0) begin n_fail++; $display("FAIL rst_exccode: got %h want 0", bus.ecl_csr_exccode_e); end
        n_checks++; if (bus.ecl_csr_badv_e !== 32'h0) begin n_fail++; $display("FAIL rst_badv: got %h want 0", bus.ecl_csr_badv_e); end
        ext_intr = 1'b0;
        clear_reqs();
        @(negedge clk);
        resetn = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_ale_same_ack();
        int kills;
        bus.valid_e = 1'b1; bus.ale_e = 1'b1;
        bus.lsu_addr_e = 32'h1003; bus.pc_e = 32'h200;
        bus.ifu_exu_redirect_ack = 1'b1;
        #2;
        n_checks++; if (bus.exu_ifu_except !== 1'b1 || bus.ecl_csr_exccode_e !== 6'h09) begin n_fail++; $display("FAIL ale_event: except=%b code=%h want 1/09", bus.exu_ifu_except, bus.ecl_csr_exccode_e); end
        n_checks++; if (bus.ecl_csr_badv_e !== 32'h1003) begin n_fail++; $display("FAIL ale_badv: got %h want 00001003", bus.ecl_csr_badv_e); end
        n_checks++; if (bus.exu_ifu_redirect !== 1'b1 || bus.exu_ifu_redirect_pc !== EENTRY) begin n_fail++; $display("FAIL ale_redirect: redir=%b pc=%h want 1/%h", bus.exu_ifu_redirect, bus.exu_ifu_redirect_pc, EENTRY); end
        n_checks++; if (bus.ecl_kill_e !== 1'b0 || bus.ecl_csr_ertn_e !== 1'b0) begin n_fail++; $display("FAIL ale_kill_ertn: kill=%b ertn=%b want 0/0", bus.ecl_kill_e, bus.ecl_csr_ertn_e); end
        kills = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            clear_reqs();
            if (i < 2) begin bus.valid_e = 1'b1; bus.sys_e = 1'b1; end
            #2;
            if (bus.ecl_kill_e === 1'b1) kills++;
            n_checks++; if (bus.exu_ifu_except !== 1'b0 || bus.exu_ifu_redirect !== 1'b0) begin n_fail++; $display("FAIL ale_drain_quiet[%0d]: except=%b redir=%b want 0/0", i, bus.exu_ifu_except, bus.exu_ifu_redirect); end
        end
        n_checks++; if (kills != DRAIN) begin n_fail++; $display("FAIL ale_kill_cycles: got %0d want %0d", kills, DRAIN); end
        @(negedge clk);
    endtask

    task automatic test_ine_sys_delayed();
        clear_reqs();
        bus.valid_e = 1'b1; bus.ine_e = 1'b1; bus.sys_e = 1'b1; bus.pc_e = 32'h340;
        #2;
        n_checks++; if (bus.exu_ifu_except !== 1'b1 || bus.ecl_csr_exccode_e !== 6'h0D || bus.ecl_csr_badv_e !== 32'h340) begin n_fail++; $display("FAIL ine_event: except=%b code=%h badv=%h want 1/0d/00000340", bus.exu_ifu_except, bus.ecl_csr_exccode_e, bus.ecl_csr_badv_e); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            clear_reqs();
            bus.valid_e = 1'b1; bus.ine_e = 1'b1;
            bus.csr_eentry = 32'hDEAD_0000;
            bus.ifu_exu_redirect_ack = (i == 2);
            #2;
            n_checks++; if (bus.exu_ifu_redirect !== 1'b1 || bus.exu_ifu_redirect_pc !== EENTRY || bus.ecl_kill_e !== 1'b1 || bus.exu_ifu_except !== 1'b0) begin n_fail++; $display("FAIL ine_redir_hold[%0d]: redir=%b pc=%h kill=%b except=%b want 1/%h/1/0", i, bus.exu_ifu_redirect, bus.exu_ifu_redirect_pc, bus.ecl_kill_e, bus.exu_ifu_except, EENTRY); end
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            clear_reqs();
            #2;
            n_checks++; if (bus.exu_ifu_redirect !== 1'b0 || bus.ecl_kill_e !== (i < 2)) begin n_fail++; $display("FAIL ine_drain[%0d]: redir=%b kill=%b want 0/%b", i, bus.exu_ifu_redirect, bus.ecl_kill_e, (i < 2)); end
        end
        bus.csr_eentry = EENTRY;
        @(negedge clk);
    endtask

    task automatic test_interrupt();
        clear_reqs();
        bus.csr_ecl_crmd_ie = 1'b1;
        bus.valid_e = 1'b1; bus.ifu_exu_redirect_ack = 1'b1; bus.pc_e = 32'h400;
        ext_intr = 1'b1;
        #2;
        n_checks++; if (bus.exu_ifu_except !== 1'b0) begin n_fail++; $display("FAIL int_sync0: except=%b want 0", bus.exu_ifu_except); end
        @(negedge clk); #2;
        n_checks++; if (bus.exu_ifu_except !== 1'b0) begin n_fail++; $display("FAIL int_sync1: except=%b want 0", bus.exu_ifu_except); end
        @(negedge clk); #2;
        n_checks++; if (bus.exu_ifu_except !== 1'b1 || bus.ecl_csr_exccode_e !== 6'h00 || bus.ecl_csr_badv_e !== 32'h400) begin n_fail++; $display("FAIL int_taken: except=%b code=%h badv=%h want 1/00/00000400", bus.exu_ifu_except, bus.ecl_csr_exccode_e, bus.ecl_csr_badv_e); end
        @(negedge clk);
        bus.csr_ecl_crmd_ie = 1'b0;
        ext_intr = 1'b0;
        @(negedge clk);
        ext_intr = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #2;
            n_checks++; if (bus.exu_ifu_except !== 1'b0) begin n_fail++; $display("FAIL int_masked[%0d]: except=%b want 0", i, bus.exu_ifu_except); end
        end
        @(negedge clk);
        bus.csr_ecl_crmd_ie = 1'b1;
        #2;
        n_checks++; if (bus.exu_ifu_except !== 1'b1 || bus.ecl_csr_exccode_e !== 6'h00) begin n_fail++; $display("FAIL int_pending_level: except=%b code=%h want 1/00", bus.exu_ifu_except, bus.ecl_csr_exccode_e); end
        @(negedge clk);
        bus.csr_ecl_crmd_ie = 1'b0;
        ext_intr = 1'b0;
        clear_reqs();
        repeat (4) @(negedge clk);
    endtask

    task automatic test_ertn();
        clear_reqs();
        bus.valid_e = 1'b1; bus.ertn_e = 1'b1; bus.ifu_exu_redirect_ack = 1'b1;
        bus.csr_era = 32'h8000;
        #2;
        n_checks++; if (bus.ecl_csr_ertn_e !== 1'b1 || bus.exu_ifu_except !== 1'b0) begin n_fail++; $display("FAIL ertn_pulse: ertn=%b except=%b want 1/0", bus.ecl_csr_ertn_e, bus.exu_ifu_except); end
        n_checks++; if (bus.ecl_csr_exccode_e !== 6'h0 || bus.ecl_csr_badv_e !== 32'h0) begin n_fail++; $display("FAIL ertn_zero_code: code=%h badv=%h want 0/0", bus.ecl_csr_exccode_e, bus.ecl_csr_badv_e); end
        n_checks++; if (bus.exu_ifu_redirect !== 1'b1 || bus.exu_ifu_redirect_pc !== 32'h8000) begin n_fail++; $display("FAIL ertn_redirect: redir=%b pc=%h want 1/00008000", bus.exu_ifu_redirect, bus.exu_ifu_redirect_pc); end
        @(negedge clk); clear_reqs();
        repeat (2) @(negedge clk);
        bus.valid_e = 1'b1; bus.ertn_e = 1'b1; bus.ifu_exu_redirect_ack = 1'b1;
        bus.csr_ecl_timer_intr = 1'b1; bus.csr_ecl_crmd_ie = 1'b1;
        #2;
        n_checks++; if (bus.exu_ifu_except !== 1'b1 || bus.ecl_csr_ertn_e !== 1'b0 || bus.ecl_csr_exccode_e !== 6'h00 || bus.exu_ifu_redirect_pc !== EENTRY) begin n_fail++; $display("FAIL ertn_vs_int: except=%b ertn=%b code=%h pc=%h want 1/0/00/%h", bus.exu_ifu_except, bus.ecl_csr_ertn_e, bus.ecl_csr_exccode_e, bus.exu_ifu_redirect_pc, EENTRY); end
        @(negedge clk);
        clear_reqs();
        bus.csr_ecl_timer_intr = 1'b0; bus.csr_ecl_crmd_ie = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset_mid_redir();
        int kills;
        clear_reqs();
        bus.valid_e = 1'b1; bus.brk_e = 1'b1; bus.pc_e = 32'h500;
        #2;
        n_checks++; if (bus.ecl_csr_exccode_e !== 6'h0C) begin n_fail++; $display("FAIL brk_code: got %h want 0c", bus.ecl_csr_exccode_e); end
        @(negedge clk); clear_reqs(); #2;
        n_checks++; if (bus.exu_ifu_redirect !== 1'b1 || bus.ecl_kill_e !== 1'b1) begin n_fail++; $display("FAIL brk_redir: redir=%b kill=%b want 1/1", bus.exu_ifu_redirect, bus.ecl_kill_e); end
        #1;
        resetn = 1'b0;
        bus.valid_e = 1'b1; bus.brk_e = 1'b1;
        #1;
        n_checks++; if (bus.exu_ifu_redirect !== 1'b0 || bus.ecl_kill_e !== 1'b0 || bus.exu_ifu_except !== 1'b0) begin n_fail++; $display("FAIL async_reset: redir=%b kill=%b except=%b want 0/0/0", bus.exu_ifu_redirect, bus.ecl_kill_e, bus.exu_ifu_except); end
        repeat (2) @(negedge clk);
        clear_reqs();
        resetn = 1'b1;
        @(negedge clk);
        bus.valid_e = 1'b1; bus.sys_e = 1'b1; bus.pc_e = 32'h600; bus.ifu_exu_redirect_ack = 1'b1;
        #2;
        n_checks++; if (bus.exu_ifu_except !== 1'b1 || bus.ecl_csr_exccode_e !== 6'h0B || bus.exu_ifu_redirect_pc !== EENTRY || bus.ecl_kill_e !== 1'b0) begin n_fail++; $display("FAIL post_reset_event: except=%b code=%h pc=%h kill=%b want 1/0b/%h/0", bus.exu_ifu_except, bus.ecl_csr_exccode_e, bus.exu_ifu_redirect_pc, bus.ecl_kill_e, EENTRY); end
        kills = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); clear_reqs(); #2;
            if (bus.ecl_kill_e === 1'b1) kills++;
        end
        n_checks++; if (kills != DRAIN) begin n_fail++; $display("FAIL post_reset_drain: got %0d want %0d", kills, DRAIN); end
    endtask

    task automatic test_random();
        logic        m_wait;
        int          m_drain;
        logic [31:0] m_target;
        logic        hist[$];
        logic        m_sync, int_p, fire, e_ex, e_ertn, e_redir, e_kill;
        int          code;
        logic [5:0]  e_code;
        logic [31:0] e_badv, e_pc;
        logic        reqs[5];
        int          codes[5];
        m_wait = 1'b0; m_drain = 0; m_target = 32'h0;
        hist.delete();
        codes = '{0, 'h0D, 'h0B, 'h0C, 'h09};
        for (int cyc = 0; cyc < 600; cyc++) begin
            @(negedge clk);
            bus.valid_e              = ($urandom_range(0, 9) < 7);
            bus.ine_e                = ($urandom_range(0, 9) == 0);
            bus.sys_e                = ($urandom_range(0, 9) == 0);
            bus.brk_e                = ($urandom_range(0, 9) == 0);
            bus.ale_e                = ($urandom_range(0, 9) == 0);
            bus.ertn_e               = ($urandom_range(0, 7) == 0);
            bus.csr_ecl_timer_intr   = ($urandom_range(0, 15) == 0);
            bus.csr_ecl_crmd_ie      = ($urandom_range(0, 1) == 1);
            bus.ifu_exu_redirect_ack = ($urandom_range(0, 9) < 4);
            if ($urandom_range(0, 7) == 0) ext_intr = ~ext_intr;
            bus.pc_e       = $urandom;
            bus.lsu_addr_e = $urandom;
            bus.csr_eentry = $urandom;
            bus.csr_era    = $urandom;
            #2;
            m_sync = (hist.size() >= SYNC) ? hist[SYNC-1] : 1'b0;
            int_p  = bus.csr_ecl_crmd_ie && (bus.csr_ecl_timer_intr || m_sync);
            reqs   = '{int_p, bus.ine_e, bus.sys_e, bus.brk_e, bus.ale_e};
            code   = -1;
            for (int k = 0; k < 5; k++) if (reqs[k] && code < 0) code = codes[k];
            fire    = !m_wait && (m_drain == 0) && bus.valid_e && (code >= 0 || bus.ertn_e);
            e_ex    = fire && (code >= 0);
            e_ertn  = fire && (code < 0);
            e_code  = e_ex ? 6'(code) : 6'h0;
            e_badv  = !e_ex ? 32'h0 : (code == 'h09) ? bus.lsu_addr_e : bus.pc_e;
            e_redir = fire || m_wait;
            e_pc    = fire ? (e_ex ? bus.csr_eentry : bus.csr_era) : m_target;
            e_kill  = m_wait || (m_drain > 0);
            n_checks++;
            if (bus.exu_ifu_except !== e_ex || bus.ecl_csr_ertn_e !== e_ertn || bus.ecl_csr_exccode_e !== e_code
                || bus.ecl_csr_badv_e !== e_badv || bus.exu_ifu_redirect !== e_redir || bus.ecl_kill_e !== e_kill
                || (e_redir && bus.exu_ifu_redirect_pc !== e_pc)) begin
                n_fail++;
                $display("FAIL rand[%0d]: got ex=%b ertn=%b code=%h badv=%h redir=%b pc=%h kill=%b want ex=%b ertn=%b code=%h badv=%h redir=%b pc=%h kill=%b",
                         cyc, bus.exu_ifu_except, bus.ecl_csr_ertn_e, bus.ecl_csr_exccode_e, bus.ecl_csr_badv_e,
                         bus.exu_ifu_redirect, bus.exu_ifu_redirect_pc, bus.ecl_kill_e,
                         e_ex, e_ertn, e_code, e_badv, e_redir, e_pc, e_kill);
            end
            if (fire) begin
                m_target = e_pc;
                if (bus.ifu_exu_redirect_ack) m_drain = DRAIN;
                else m_wait = 1'b1;
            end else if (m_wait) begin
                if (bus.ifu_exu_redirect_ack) begin m_wait = 1'b0; m_drain = DRAIN; end
            end else if (m_drain > 0) begin
                m_drain--;
            end
            hist.push_front(ext_intr);
            if (hist.size() > SYNC) void'(hist.pop_back());
        end
        @(negedge clk);
        init_inputs();
        ext_intr = 1'b0;
        repeat (DRAIN + 8) @(negedge clk);
    endtask

`ifdef CPU7_EXC_CNT_EN
    task automatic test_counters();
        resetn = 1'b0;
        init_inputs();
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        n_checks++; if (exc_cnt !== 32'h0 || int_cnt !== 32'h0) begin n_fail++; $display("FAIL cnt_reset: exc=%h int=%h want 0/0", exc_cnt, int_cnt); end
        for (int k = 0; k < 4; k++) begin
            clear_reqs();
            bus.valid_e = 1'b1; bus.ifu_exu_redirect_ack = 1'b1;
            case (k)
                0: bus.ine_e = 1'b1;
                1: bus.sys_e = 1'b1;
                2: bus.brk_e = 1'b1;
                default: begin bus.csr_ecl_timer_intr = 1'b1; bus.csr_ecl_crmd_ie = 1'b1; end
            endcase
            @(negedge clk);
            init_inputs();
            repeat (DRAIN + 1) @(negedge clk);
        end
        n_checks++; if (exc_cnt !== 32'd4 || int_cnt !== 32'd1) begin n_fail++; $display("FAIL cnt_values: exc=%0d int=%0d want 4/1", exc_cnt, int_cnt); end
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_ale_same_ack();
        test_ine_sys_delayed();
        test_interrupt();
        test_ertn();
        test_reset_mid_redir();
        test_random();
`ifdef CPU7_EXC_CNT_EN
        test_counters();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
